// File: rtl/brew_sched_pkg.sv
// Shared definitions for the brew scheduler: state encodings and the default
// tank/watchdog sizing that the brewer FSM also uses.
package brew_sched_pkg;

    localparam int CUPS_DEFAULT    = 3;
    localparam int TIMEOUT_DEFAULT = 20;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE       = 3'b000;
    localparam state_t ST_DISPATCH   = 3'b001;
    localparam state_t ST_BREWING    = 3'b010;
    localparam state_t ST_DONE       = 3'b011;
    localparam state_t ST_NEED_WATER = 3'b100;
    localparam state_t ST_FAULT      = 3'b101;

endpackage

// File: rtl/brew_scheduler_if.sv
// Station/brewer bus of the brew scheduler. The slave side is the scheduler;
// the master side is whatever drives the buttons and the brewer.
interface brew_scheduler_if #(
    parameter int CUP_W = $clog2(brew_sched_pkg::CUPS_DEFAULT + 1)
) ();
    logic [1:0]       req;
    logic             brew_done;
    logic             refill;
    logic             fault_clr;
    logic [1:0]       grant;
    logic             brew_start;
    logic [1:0]       served;
    logic [1:0]       pending;
    logic [CUP_W-1:0] cups_left;
    logic             need_water;
    logic             fault;
    logic [2:0]       state;

    modport master (
        output req, brew_done, refill, fault_clr,
        input  grant, brew_start, served, pending, cups_left, need_water, fault, state
    );

    modport slave (
        input  req, brew_done, refill, fault_clr,
        output grant, brew_start, served, pending, cups_left, need_water, fault, state
    );
endinterface

// File: rtl/brew_scheduler_rr_pick2.sv
// Two-way round-robin pick: a sole pending station wins; when both are
// pending, the one that was not served last wins. Purely combinational.
module rr_pick2 (
    input  logic [1:0] pending,
    input  logic       last_served,
    output logic [1:0] winner
);
    always_comb begin
        case (pending)
            2'b01:   winner = 2'b01;
            2'b10:   winner = 2'b10;
            2'b11:   winner = last_served ? 2'b01 : 2'b10;
            default: winner = 2'b00;
        endcase
    end
endmodule

// File: rtl/brew_scheduler.sv
// Shares one brew unit between two stations: latches orders, grants them
// round-robin, runs the brewer under a watchdog and tracks tank water.
module brew_scheduler
    import brew_sched_pkg::*;
#(
    parameter int CUPS    = CUPS_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input logic             clk_1Hz,
    input logic             reset_n,
    brew_scheduler_if.slave bus
);
    localparam int CUP_W = $clog2(CUPS + 1);
    localparam int TMR_W = $clog2(TIMEOUT);
    localparam logic [CUP_W-1:0] CUPS_FULL = CUP_W'(CUPS);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT - 1);

    state_t           state_q, state_n;
    logic [1:0]       pending_q, pending_n;
    logic [1:0]       winner_q, pick;
    logic             last_served_q;
    logic [CUP_W-1:0] cups_q;
    logic [TMR_W-1:0] timer_q;

    logic [1:0] grant, served;
    logic       brew_start, need_water, fault;
    logic       dispatch_go, refill_ok;

    rr_pick2 u_pick (
        .pending     (pending_q),
        .last_served (last_served_q),
        .winner      (pick)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process order.
    always_ff @(posedge clk_1Hz or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_n;
    end

    always_comb begin
        // NOTE: defaulting every always_comb output first prevents latch inference.
        state_n = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cups_q == '0)         state_n = ST_NEED_WATER;
                else if (pending_q != '0) state_n = ST_DISPATCH;
            end
            ST_DISPATCH:   state_n = ST_BREWING;
            ST_BREWING: begin
                // brew_done beats the watchdog when both land together
                if (bus.brew_done)          state_n = ST_DONE;
                else if (timer_q == TMR_LAST) state_n = ST_FAULT;
            end
            ST_DONE:       state_n = ST_IDLE;
            ST_NEED_WATER: if (bus.refill)    state_n = ST_IDLE;
            ST_FAULT:      if (bus.fault_clr) state_n = ST_IDLE;
            default:       state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        grant      = 2'b00;
        served     = 2'b00;
        brew_start = 1'b0;
        need_water = 1'b0;
        fault      = 1'b0;
        case (state_q)
            ST_DISPATCH: begin
                grant      = winner_q;
                brew_start = 1'b1;
            end
            ST_BREWING:    grant = winner_q;
            ST_DONE: begin
                grant  = winner_q;
                served = winner_q;
            end
            ST_NEED_WATER: need_water = 1'b1;
            ST_FAULT:      fault      = 1'b1;
            default: ;
        endcase
    end

    assign dispatch_go = (state_q == ST_IDLE) && (state_n == ST_DISPATCH);
    assign refill_ok   = bus.refill &&
                         (state_q inside {ST_IDLE, ST_NEED_WATER, ST_FAULT});
    // A granted station cannot re-order; DONE clears the winner and wins over a new press.
    assign pending_n   = (pending_q | (bus.req & ~grant)) & ~served;

    // NOTE: every register here, including the cup count, has a defined reset
    // value because the block must come out of reset in a known IDLE state.
    always_ff @(posedge clk_1Hz or negedge reset_n) begin
        if (!reset_n) begin
            pending_q     <= 2'b00;
            winner_q      <= 2'b00;
            last_served_q <= 1'b1;
            cups_q        <= CUPS_FULL;
            timer_q       <= '0;
        end else begin
            pending_q <= pending_n;

            if (dispatch_go) winner_q <= pick;

            if (refill_ok)        cups_q <= dispatch_go ? CUPS_FULL - CUP_W'(1) : CUPS_FULL;
            else if (dispatch_go) cups_q <= cups_q - CUP_W'(1);

            if (state_q == ST_DISPATCH)
                timer_q <= '0;
            else if (state_q == ST_BREWING && timer_q != TMR_LAST)
                timer_q <= timer_q + TMR_W'(1);

            if (state_q == ST_DONE) last_served_q <= winner_q[1];
        end
    end

    assign bus.grant      = grant;
    assign bus.brew_start = brew_start;
    assign bus.served     = served;
    assign bus.pending    = pending_q;
    assign bus.cups_left  = cups_q;
    assign bus.need_water = need_water;
    assign bus.fault      = fault;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_brew_scheduler.sv
// Directed bench for brew_scheduler: a vector table for the basic and
// round-robin flows plus hand sequences for watchdog, expiry race and reset.
module tb_brew_scheduler;
    import brew_sched_pkg::*;

    logic clk_1Hz = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp   = 0;
    int   n_fail  = 0;

    brew_scheduler_if #(.CUP_W(2)) bus ();

    brew_scheduler dut (
        .clk_1Hz (clk_1Hz),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk_1Hz = ~clk_1Hz;

    typedef struct {
        logic [1:0] req;
        logic       done;
        logic       refill;
        logic       clr;
        logic [2:0] st;
        logic [1:0] gnt;
        logic       bs;
        logic [1:0] srv;
        logic [1:0] pnd;
        logic [1:0] cups;
        logic       nw;
        logic       flt;
    } vec_t;

    vec_t vq[$];
    int   seg_b;

    function automatic void add(logic [1:0] req, logic done, logic refill, logic clr,
                                logic [2:0] st, logic [1:0] gnt, logic bs, logic [1:0] srv,
                                logic [1:0] pnd, logic [1:0] cups, logic nw, logic flt);
        vec_t v;
        v.req = req; v.done = done; v.refill = refill; v.clr = clr;
        v.st = st; v.gnt = gnt; v.bs = bs; v.srv = srv;
        v.pnd = pnd; v.cups = cups; v.nw = nw; v.flt = flt;
        vq.push_back(v);
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic [2:0] st, input logic [1:0] gnt,
                              input logic bs, input logic [1:0] srv, input logic [1:0] pnd,
                              input logic [1:0] cups, input logic nw, input logic flt);
        check({tag, ".state"},      8'(bus.state),      8'(st));
        check({tag, ".grant"},      8'(bus.grant),      8'(gnt));
        check({tag, ".brew_start"}, 8'(bus.brew_start), 8'(bs));
        check({tag, ".served"},     8'(bus.served),     8'(srv));
        check({tag, ".pending"},    8'(bus.pending),    8'(pnd));
        check({tag, ".cups_left"},  8'(bus.cups_left),  8'(cups));
        check({tag, ".need_water"}, 8'(bus.need_water), 8'(nw));
        check({tag, ".fault"},      8'(bus.fault),      8'(flt));
    endtask

    task automatic step();
        @(posedge clk_1Hz);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
    endtask

    task automatic idle_inputs();
        bus.req = 2'b00; bus.brew_done = 1'b0; bus.refill = 1'b0; bus.fault_clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n_brew;
        idle_inputs();

        // Segment A: single order from station 0.
        //   req    dn rf cl  st  gnt bs srv  pnd  cups nw fl
        add(2'b01, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b01, 3, 0, 0);
        add(2'b00, 0, 0, 0, 1, 2'b01, 1, 2'b00, 2'b01, 2, 0, 0);
        add(2'b00, 0, 0, 0, 2, 2'b01, 0, 2'b00, 2'b01, 2, 0, 0);
        add(2'b00, 0, 0, 0, 2, 2'b01, 0, 2'b00, 2'b01, 2, 0, 0);
        add(2'b00, 1, 0, 0, 3, 2'b01, 0, 2'b01, 2'b01, 2, 0, 0);
        add(2'b00, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2, 0, 0);
        // Segment B (after reset): both held, served 0,1,0, then water out and refill.
        seg_b = vq.size();
        add(2'b11, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b11, 3, 0, 0);
        add(2'b11, 0, 0, 0, 1, 2'b01, 1, 2'b00, 2'b11, 2, 0, 0);
        add(2'b11, 0, 0, 0, 2, 2'b01, 0, 2'b00, 2'b11, 2, 0, 0);
        add(2'b11, 1, 0, 0, 3, 2'b01, 0, 2'b01, 2'b11, 2, 0, 0);
        add(2'b11, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b10, 2, 0, 0);
        add(2'b11, 0, 0, 0, 1, 2'b10, 1, 2'b00, 2'b11, 1, 0, 0);
        add(2'b11, 0, 0, 0, 2, 2'b10, 0, 2'b00, 2'b11, 1, 0, 0);
        add(2'b11, 1, 0, 0, 3, 2'b10, 0, 2'b10, 2'b11, 1, 0, 0);
        add(2'b11, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b01, 1, 0, 0);
        add(2'b11, 0, 0, 0, 1, 2'b01, 1, 2'b00, 2'b11, 0, 0, 0);
        add(2'b11, 0, 0, 0, 2, 2'b01, 0, 2'b00, 2'b11, 0, 0, 0);
        add(2'b11, 1, 0, 0, 3, 2'b01, 0, 2'b01, 2'b11, 0, 0, 0);
        add(2'b11, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b10, 0, 0, 0);
        add(2'b00, 0, 0, 0, 4, 2'b00, 0, 2'b00, 2'b10, 0, 1, 0);
        add(2'b00, 0, 0, 0, 4, 2'b00, 0, 2'b00, 2'b10, 0, 1, 0);
        add(2'b00, 0, 1, 0, 0, 2'b00, 0, 2'b00, 2'b10, 3, 0, 0);
        add(2'b00, 0, 0, 0, 1, 2'b10, 1, 2'b00, 2'b10, 2, 0, 0);
        add(2'b00, 0, 0, 0, 2, 2'b10, 0, 2'b00, 2'b10, 2, 0, 0);

        #12;
        check_outs("reset", 3'd0, 2'b00, 1'b0, 2'b00, 2'b00, 2'd3, 1'b0, 1'b0);
        reset_n = 1'b1;

        foreach (vq[i]) begin
            if (i == seg_b) do_reset();
            bus.req = vq[i].req; bus.brew_done = vq[i].done;
            bus.refill = vq[i].refill; bus.fault_clr = vq[i].clr;
            step();
            check_outs($sformatf("vec%0d", i), vq[i].st, vq[i].gnt, vq[i].bs, vq[i].srv,
                       vq[i].pnd, vq[i].cups, vq[i].nw, vq[i].flt);
        end
        idle_inputs();

        // Watchdog: station 1 is brewing with no brew_done; refill mid-brew is ignored.
        n_brew = 1;
        for (int k = 0; k < 40; k++) begin
            bus.refill = (k == 3);
            step();
            if (k == 3) check("refill_in_brewing", 8'(bus.cups_left), 8'd2);
            if (bus.state != ST_BREWING) break;
            n_brew++;
        end
        bus.refill = 1'b0;
        check("brewing_cycles_before_fault", 8'(n_brew), 8'(TIMEOUT_DEFAULT));
        check_outs("fault", 3'd5, 2'b00, 1'b0, 2'b00, 2'b10, 2'd2, 1'b0, 1'b1);
        step();
        check_outs("fault_hold", 3'd5, 2'b00, 1'b0, 2'b00, 2'b10, 2'd2, 1'b0, 1'b1);
        bus.fault_clr = 1'b1;
        step();
        bus.fault_clr = 1'b0;
        check_outs("fault_clr", 3'd0, 2'b00, 1'b0, 2'b00, 2'b10, 2'd2, 1'b0, 1'b0);
        step();
        check_outs("retry_dispatch", 3'd1, 2'b10, 1'b1, 2'b00, 2'b10, 2'd1, 1'b0, 1'b0);

        // brew_done lands on the very cycle the watchdog expires.
        step();
        for (int k = 0; k < TIMEOUT_DEFAULT - 1; k++) step();
        check("pre_expiry_state", 8'(bus.state), 8'(ST_BREWING));
        bus.brew_done = 1'b1;
        step();
        bus.brew_done = 1'b0;
        check_outs("done_on_expiry", 3'd3, 2'b10, 1'b0, 2'b10, 2'b10, 2'd1, 1'b0, 1'b0);
        bus.req = 2'b10;
        step();
        bus.req = 2'b00;
        check_outs("clear_beats_set", 3'd0, 2'b00, 1'b0, 2'b00, 2'b00, 2'd1, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a brew.
        bus.req = 2'b01;
        step();
        bus.req = 2'b00;
        step();
        check_outs("last_dispatch", 3'd1, 2'b01, 1'b1, 2'b00, 2'b01, 2'd0, 1'b0, 1'b0);
        step();
        check("mid_brew_state", 8'(bus.state), 8'(ST_BREWING));
        #2;
        reset_n = 1'b0;
        #1;
        check_outs("async_reset", 3'd0, 2'b00, 1'b0, 2'b00, 2'b00, 2'd3, 1'b0, 1'b0);
        #2;
        reset_n = 1'b1;
        step();
        check_outs("post_reset", 3'd0, 2'b00, 1'b0, 2'b00, 2'b00, 2'd3, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
